udp_roce_connection_manager_tx_64: RTL and testbench

Transmit-side RoCE connection-manager serializer. Accepts a queue-pair info bundle and a transfer-metadata bundle, and emits them as one 44-byte UDP control frame on the 64-bit UDP header and AXI-Stream payload interface toward the UDP/IP TX stack. The frame layout is exactly the one the peer's 64-bit connection-manager receiver parses. The block sits between host/control logic and the UDP TX mux.

---
 rtl/udp_roce_connection_manager_tx_64.sv | 162 ++++++++++++++++
 tb/tb_udp_roce_connection_manager_tx_64.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_roce_connection_manager_tx_64.sv
// rtl/udp_roce_connection_manager_tx_64.sv - RoCE CM descriptor to 44-byte UDP control frame serializer
// Optional UDP checksum generation: ROCE_CM_TX_UDP_CHECKSUM_EN
module udp_roce_connection_manager_tx_64 #(
  parameter logic [15:0] LOCAL_UDP_PORT = 16'h4321,
  parameter logic [15:0] DEST_UDP_PORT  = 16'h4321,
  parameter logic [7:0]  IP_TTL         = 8'd64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_req_valid,
  output logic         s_req_ready,
  input  logic [199:0] s_qp_info,
  input  logic [151:0] s_txmeta,
  input  logic [31:0]  s_local_ip,
  input  logic [31:0]  s_dest_ip,
  output logic         m_udp_hdr_valid,
  input  logic         m_udp_hdr_ready,
  output logic [5:0]   m_ip_dscp,
  output logic [1:0]   m_ip_ecn,
  output logic [7:0]   m_ip_ttl,
  output logic [31:0]  m_ip_source_ip,
  output logic [31:0]  m_ip_dest_ip,
  output logic [15:0]  m_udp_source_port,
  output logic [15:0]  m_udp_dest_port,
  output logic [15:0]  m_udp_length,
  output logic [15:0]  m_udp_checksum,
  output logic [63:0]  m_udp_payload_axis_tdata,
  output logic [7:0]   m_udp_payload_axis_tkeep,
  output logic         m_udp_payload_axis_tvalid,
  input  logic         m_udp_payload_axis_tready,
  output logic         m_udp_payload_axis_tlast,
  output logic         m_udp_payload_axis_tuser,
  output logic         busy
);

  localparam logic [15:0] UDP_LEN = 16'd52;

`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, CSUM, HDR, PAYLOAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
`endif

  state_t       state;
  logic [2:0]   beat;
  logic [351:0] frame_r;      // 44 frame bytes, byte 0 in the top bits
  logic [31:0]  src_ip_r;
  logic [31:0]  dst_ip_r;
  logic         hdr_valid_r;
  logic         tvalid_r;
  logic [351:0] frame_in;
  logic [63:0]  word_be;
  logic         unused_bits;

  assign frame_in = {7'b0, s_qp_info[0], s_qp_info[31:8], s_qp_info[55:32], s_qp_info[79:56],
                     s_qp_info[103:80], s_qp_info[135:104], s_qp_info[199:136],
                     4'b0, s_txmeta[3:0], s_txmeta[39:8], s_txmeta[103:40],
                     s_txmeta[135:104], s_txmeta[151:136]};
  assign unused_bits = ^{s_qp_info[7:1], s_txmeta[7:4]};

`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
  logic [15:0] csum_r;
  logic [15:0] csum_calc;
  logic [31:0] acc;

  always_comb begin
    acc = 32'(src_ip_r[31:16]) + 32'(src_ip_r[15:0]) + 32'(dst_ip_r[31:16]) + 32'(dst_ip_r[15:0])
        + 32'h0011 + 32'(UDP_LEN) + 32'(LOCAL_UDP_PORT) + 32'(DEST_UDP_PORT) + 32'(UDP_LEN);
    for (int i = 0; i < 22; i++) acc = acc + 32'(frame_r[351-16*i -: 16]);
    acc = 32'(acc[15:0]) + 32'(acc[31:16]);
    acc = 32'(acc[15:0]) + 32'(acc[31:16]);
    csum_calc = ~acc[15:0];
  end
  assign m_udp_checksum = csum_r;
`else
  assign m_udp_checksum = 16'h0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= 3'd0;
      frame_r     <= '0;
      src_ip_r    <= '0;
      dst_ip_r    <= '0;
      hdr_valid_r <= 1'b0;
      tvalid_r    <= 1'b0;
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
      csum_r      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (s_req_valid) begin
          frame_r  <= frame_in;
          src_ip_r <= s_local_ip;
          dst_ip_r <= s_dest_ip;
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
          state <= CSUM;
`else
          state       <= HDR;
          hdr_valid_r <= 1'b1;
`endif
        end
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
        CSUM: begin
          csum_r      <= (csum_calc == 16'h0000) ? 16'hFFFF : csum_calc;
          state       <= HDR;
          hdr_valid_r <= 1'b1;
        end
`endif
        HDR: if (m_udp_hdr_ready) begin
          hdr_valid_r <= 1'b0;
          tvalid_r    <= 1'b1;
          beat        <= 3'd0;
          state       <= PAYLOAD;
        end
        PAYLOAD: if (m_udp_payload_axis_tready) begin
          if (beat == 3'd5) begin
            tvalid_r <= 1'b0;
            state    <= IDLE;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pick the big-endian 8-byte slice, then put wire byte 0 in tdata[7:0]
  always_comb begin
    case (beat)
      3'd0: word_be = frame_r[351:288];
      3'd1: word_be = frame_r[287:224];
      3'd2: word_be = frame_r[223:160];
      3'd3: word_be = frame_r[159:96];
      3'd4: word_be = frame_r[95:32];
      3'd5: word_be = {frame_r[31:0], 32'b0};
      default: word_be = '0;
    endcase
    m_udp_payload_axis_tdata = '0;
    if (tvalid_r)
      for (int k = 0; k < 8; k++) m_udp_payload_axis_tdata[8*k +: 8] = word_be[63-8*k -: 8];
  end

  assign s_req_ready               = (state == IDLE) && !rst;
  assign busy                      = (state != IDLE);
  assign m_udp_hdr_valid           = hdr_valid_r;
  assign m_udp_payload_axis_tvalid = tvalid_r;
  assign m_udp_payload_axis_tkeep  = !tvalid_r ? 8'h00 : (beat == 3'd5) ? 8'h0F : 8'hFF;
  assign m_udp_payload_axis_tlast  = tvalid_r && (beat == 3'd5);
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign m_ip_dscp                 = 6'd0;
  assign m_ip_ecn                  = 2'd0;
  assign m_ip_ttl                  = IP_TTL;
  assign m_ip_source_ip            = src_ip_r;
  assign m_ip_dest_ip              = dst_ip_r;
  assign m_udp_source_port         = LOCAL_UDP_PORT;
  assign m_udp_dest_port           = DEST_UDP_PORT;
  assign m_udp_length              = UDP_LEN;

endmodule

// File: tb/tb_udp_roce_connection_manager_tx_64.sv
// tb/tb_udp_roce_connection_manager_tx_64.sv - self-checking bench for udp_roce_connection_manager_tx_64
module tb_udp_roce_connection_manager_tx_64;
  logic         clk = 1'b0;
  logic         rst;
  logic         s_req_valid;
  logic         s_req_ready;
  logic [199:0] s_qp_info;
  logic [151:0] s_txmeta;
  logic [31:0]  s_local_ip, s_dest_ip;
  logic         m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]   m_ip_dscp;
  logic [1:0]   m_ip_ecn;
  logic [7:0]   m_ip_ttl;
  logic [31:0]  m_ip_source_ip, m_ip_dest_ip;
  logic [15:0]  m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tvalid, tready, tlast, tuser, busy;

  udp_roce_connection_manager_tx_64 dut (
    .clk(clk), .rst(rst), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_qp_info(s_qp_info), .s_txmeta(s_txmeta), .s_local_ip(s_local_ip), .s_dest_ip(s_dest_ip),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(tdata), .m_udp_payload_axis_tkeep(tkeep),
    .m_udp_payload_axis_tvalid(tvalid), .m_udp_payload_axis_tready(tready),
    .m_udp_payload_axis_tlast(tlast), .m_udp_payload_axis_tuser(tuser), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [199:0] d_qp;
  logic [151:0] d_tm;
  logic [31:0]  d_lip, d_dip;
  logic [63:0]  exp_w [6];
  logic [15:0]  exp_csum;
  logic [63:0]  got_w [6];
  logic [15:0]  got_csum;
  logic [7:0]   mq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mq.push_back(v[8*i +: 8]);
  endfunction

  // Reference frame: fields pushed as big-endian byte strings, then split into beats
  function automatic void build_model();
    int unsigned sum;
    logic [15:0] c;
    mq.delete();
    put(64'(d_qp[0]), 1);         put(64'(d_qp[31:8]), 3);     put(64'(d_qp[55:32]), 3);
    put(64'(d_qp[79:56]), 3);     put(64'(d_qp[103:80]), 3);   put(64'(d_qp[135:104]), 4);
    put(64'(d_qp[199:136]), 8);   put(64'(d_tm[3:0]), 1);      put(64'(d_tm[39:8]), 4);
    put(64'(d_tm[103:40]), 8);    put(64'(d_tm[135:104]), 4);  put(64'(d_tm[151:136]), 2);
    while (mq.size() < 48) mq.push_back(8'h00);
    for (int b = 0; b < 6; b++)
      for (int k = 0; k < 8; k++) exp_w[b][8*k +: 8] = mq[8*b + k];
    sum = d_lip[31:16] + d_lip[15:0] + d_dip[31:16] + d_dip[15:0] + 32'h11 + 32'd52
        + 32'h4321 + 32'h4321 + 32'd52;
    for (int i = 0; i < 22; i++) sum += {16'h0, mq[2*i], mq[2*i + 1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    c = ~sum[15:0];
    exp_csum = (c == 16'h0) ? 16'hFFFF : c;
  endfunction

  task automatic rand_desc();
    logic [223:0] t;
    logic [159:0] u;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    u = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    d_qp = t[199:0];
    d_tm = u[151:0];
    d_lip = $urandom();
    d_dip = $urandom();
  endtask

  task automatic run_frame(input int hdr_delay, input int stall_beat, input int stall_len);
    build_model();
    @(negedge clk);
    check("req_ready_idle", 64'(s_req_ready), 64'd1);
    s_req_valid = 1'b1;
    s_qp_info = d_qp; s_txmeta = d_tm; s_local_ip = d_lip; s_dest_ip = d_dip;
    @(negedge clk);
    s_req_valid = 1'b0;
    s_qp_info = ~d_qp; s_txmeta = ~d_tm; s_local_ip = $urandom(); s_dest_ip = $urandom();
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
    check("csum_cycle_no_hdr", 64'(m_udp_hdr_valid), 64'd0);
    @(negedge clk);
`endif
    check("hdr_valid", 64'(m_udp_hdr_valid), 64'd1);
    check("hdr_len", 64'(m_udp_length), 64'd52);
    check("hdr_ports", {m_udp_source_port, m_udp_dest_port}, 64'h43214321);
    check("hdr_ips", {m_ip_source_ip, m_ip_dest_ip}, {d_lip, d_dip});
    check("hdr_ttl", 64'(m_ip_ttl), 64'd64);
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
    check("hdr_csum", 64'(m_udp_checksum), 64'(exp_csum));
`else
    check("hdr_csum", 64'(m_udp_checksum), 64'd0);
`endif
    got_csum = m_udp_checksum;
    for (int d = 0; d < hdr_delay; d++) begin
      check("no_beat_before_hdr", 64'(tvalid), 64'd0);
      check("hdr_hold", {31'b0, m_udp_hdr_valid, m_ip_source_ip}, {31'b0, 1'b1, d_lip});
      @(negedge clk);
    end
    m_udp_hdr_ready = 1'b1;
    @(negedge clk);
    m_udp_hdr_ready = 1'b0;
    check("hdr_dropped", 64'(m_udp_hdr_valid), 64'd0);
    for (int b = 0; b < 6; b++) begin
      if (b == stall_beat)
        for (int s = 0; s < stall_len; s++) begin
          check("stall_data", tdata, exp_w[b]);
          check("stall_valid", 64'({tvalid, tlast}), 64'({1'b1, b == 5}));
          @(negedge clk);
        end
      check("beat_valid", 64'(tvalid), 64'd1);
      check("beat_data", tdata, exp_w[b]);
      check("beat_keep_last", 64'({tkeep, tlast}), 64'({(b == 5) ? 8'h0F : 8'hFF, b == 5}));
      got_w[b] = tdata;
      tready = 1'b1;
      @(negedge clk);
      tready = 1'b0;
    end
    check("after_last_valid", 64'(tvalid), 64'd0);
    check("after_last_ready_busy", 64'({s_req_ready, busy}), 64'b10);
  endtask

  logic [199:0] a_qp;
  logic [151:0] a_tm;
  logic [31:0]  a_lip, a_dip;
  logic [63:0]  q_exp [$];
  logic [63:0]  q_got [$];
  int hdr_idx [$];
  int tl_idx [$];
  int idle_idx [$];

  initial begin
    rst = 1'b1; s_req_valid = 1'b0; s_qp_info = '0; s_txmeta = '0;
    s_local_ip = '0; s_dest_ip = '0; m_udp_hdr_ready = 1'b0; tready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(s_req_ready), 64'd0);
    check("rst_valids", 64'({m_udp_hdr_valid, tvalid, tlast, busy, tuser}), 64'd0);
    check("rst_keep_data", {tdata[55:0], tkeep}, 64'd0);
    check("rst_misc", {m_ip_dscp, m_ip_ecn, m_udp_checksum, m_ip_source_ip}, 64'd0);
    check("rst_consts", {m_ip_ttl, m_udp_length, m_udp_source_port}, 64'h40_0034_4321);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(s_req_ready), 64'd1);

    // byte order
    d_qp = '0; d_tm = '0; d_qp[0] = 1'b1; d_qp[31:8] = 24'h123456;
    d_lip = 32'h0A000001; d_dip = 32'h0A000002;
    run_frame(0, -1, 0);
    check("byte_order_beat0", 64'(got_w[0][31:0]), 64'h56341201);

    // DMA fields
    d_qp = '0; d_tm = '0; d_tm[135:104] = 32'h00010000; d_tm[151:136] = 16'h12B7;
    run_frame(1, -1, 0);
    check("dma_beat4_hi", 64'(got_w[4][63:48]), 64'h0100);
    check("dma_beat5_lo", 64'(got_w[5][31:0]), 64'hB7120000);
    check("dma_beat5_pad", 64'(got_w[5][63:32]), 64'd0);

    // backpressure: header held 4 cycles, beat 2 stalled 3 cycles
    rand_desc();
    run_frame(4, 2, 3);

    // checksum of all-zero descriptor
    d_qp = '0; d_tm = '0; d_lip = '0; d_dip = '0;
    run_frame(0, -1, 0);
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
    check("zero_csum", 64'(got_csum), 64'h7944);
`else
    check("zero_csum", 64'(got_csum), 64'h0000);
`endif

    for (int n = 0; n < 4; n++) begin
      rand_desc();
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end

    // back-to-back with s_req_valid held high
    rand_desc(); build_model();
    a_qp = d_qp; a_tm = d_tm; a_lip = d_lip; a_dip = d_dip;
    for (int b = 0; b < 6; b++) q_exp.push_back(exp_w[b]);
    rand_desc(); build_model();
    for (int b = 0; b < 6; b++) q_exp.push_back(exp_w[b]);
    @(negedge clk);
    s_req_valid = 1'b1; s_qp_info = a_qp; s_txmeta = a_tm; s_local_ip = a_lip; s_dest_ip = a_dip;
    m_udp_hdr_ready = 1'b1; tready = 1'b1;
    @(negedge clk);
    s_qp_info = d_qp; s_txmeta = d_tm; s_local_ip = d_lip; s_dest_ip = d_dip;
    for (int idx = 0; idx < 40; idx++) begin
      if (tvalid) q_got.push_back(tdata);
      if (tvalid && tlast) tl_idx.push_back(idx);
      if (m_udp_hdr_valid) hdr_idx.push_back(idx);
      if (!busy) begin
        idle_idx.push_back(idx);
        if (idle_idx.size() == 2) begin
          s_req_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    s_req_valid = 1'b0; m_udp_hdr_ready = 1'b0; tready = 1'b0;
    check("b2b_completed", 64'(idle_idx.size()), 64'd2);
    check("b2b_hdr_count", 64'(hdr_idx.size()), 64'd2);
    check("b2b_last_count", 64'(tl_idx.size()), 64'd2);
    check("b2b_beats", 64'(q_got.size()), 64'd12);
    if (hdr_idx.size() == 2 && tl_idx.size() == 2 && idle_idx.size() == 2) begin
      check("b2b_hdr1_time", 64'(hdr_idx[0]), 64'(OFF));
      check("b2b_last1_time", 64'(tl_idx[0]), 64'(OFF + 6));
      check("b2b_idle_time", 64'(idle_idx[0]), 64'(tl_idx[0] + 1));
      check("b2b_hdr2_gap", 64'(hdr_idx[1] - tl_idx[0]), 64'(2 + OFF));
    end
    if (q_got.size() == 12)
      for (int i = 0; i < 12; i++) check("b2b_data", q_got[i], q_exp[i]);

    // reset during beat 3
    rand_desc(); build_model();
    @(negedge clk);
    s_req_valid = 1'b1; s_qp_info = d_qp; s_txmeta = d_tm; s_local_ip = d_lip; s_dest_ip = d_dip;
    @(negedge clk);
    s_req_valid = 1'b0;
`ifdef ROCE_CM_TX_UDP_CHECKSUM_EN
    @(negedge clk);
`endif
    m_udp_hdr_ready = 1'b1;
    @(negedge clk);
    m_udp_hdr_ready = 1'b0; tready = 1'b1;
    repeat (3) @(negedge clk);
    tready = 1'b0;
    check("mid_beat3", tdata, exp_w[3]);
    rst = 1'b1;
    #1;
    check("mid_rst_valids", 64'({tvalid, m_udp_hdr_valid, tlast, busy, s_req_ready}), 64'd0);
    check("mid_rst_data", tdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 64'(s_req_ready), 64'd1);
    rand_desc();
    run_frame(1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
